miso_bus_arbiter: RTL and testbench

//   Clocked, parametrised successor to the combinational shared-MISO selector.

---
 rtl/miso_bus_arbiter_if.sv | 33 +++
 rtl/miso_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_miso_bus_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/miso_bus_arbiter_if.sv
// Shared-MISO bus bundle: master-side selects and per-slave MISO in,
// arbitrated MISO plus status/error reporting out.
interface miso_bus_arbiter_if #(
    parameter int NSLAVE   = 4,
    parameter int ERRCNT_W = 8
);
    localparam int IDX_W = $clog2(NSLAVE);

    logic [NSLAVE-1:0]   cs_n;
    logic [NSLAVE-1:0]   miso_in;
    logic                err_clr;
    logic                miso_out;
    logic                miso_oe;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_valid;
    logic                contention;
    logic                err_sticky;
    logic [ERRCNT_W-1:0] err_count;

    // Arbiter side
    modport slave (
        input  cs_n, miso_in, err_clr,
        output miso_out, miso_oe, sel_idx, sel_valid,
               contention, err_sticky, err_count
    );

    // Driver/observer side (SPI master and slave models)
    modport master (
        output cs_n, miso_in, err_clr,
        input  miso_out, miso_oe, sel_idx, sel_valid,
               contention, err_sticky, err_count
    );
endinterface

// File: rtl/miso_bus_arbiter.sv
// Registered shared-MISO arbiter. Decodes active-low chip selects, inserts a
// break-before-make turnaround before a slave is allowed to drive, parks the
// line at PARK_VAL when released, and flags/counts multi-select contention.
module miso_bus_arbiter #(
    parameter int   NSLAVE   = 4,
    parameter int   TURN_CYC = 1,
    parameter logic PARK_VAL = 1'b1,
    parameter int   ERRCNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    miso_bus_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NSLAVE);
    // Turnaround counter preload; a zero-turnaround config still spends one
    // TURN cycle when switching slaves out of DRIVE, so clamp at zero.
    localparam logic [3:0] TURN_LOAD = (TURN_CYC == 0) ? 4'd0 : 4'(TURN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TURN,
        S_DRIVE,
        S_FAULT
    } state_t;

    state_t              state;
    logic [3:0]          turn_cnt;
    logic [IDX_W-1:0]    sel_idx_q;
    logic                sel_valid_q;
    logic                miso_out_q;
    logic                miso_oe_q;
    logic                contention_q;
    logic                err_sticky_q;
    logic [ERRCNT_W-1:0] err_count_q;

    logic             dec_none;
    logic             dec_one;
    logic             dec_multi;
    logic [IDX_W-1:0] low_idx;
    logic             fault_entry;

    // Classify the select vector and find the asserted slave index
    always_comb begin
        dec_none  = &bus.cs_n;
        dec_one   = $onehot(~bus.cs_n);
        dec_multi = !dec_none && !dec_one;
        low_idx   = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (!bus.cs_n[i]) low_idx = IDX_W'(i);
        end
        fault_entry = dec_multi && (state != S_FAULT);
    end

    // Selection FSM with registered outputs and contention bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            turn_cnt     <= '0;
            sel_idx_q    <= '0;
            sel_valid_q  <= 1'b0;
            miso_out_q   <= PARK_VAL;
            miso_oe_q    <= 1'b0;
            contention_q <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            contention_q <= 1'b0;
            if (fault_entry) begin
                // Multi-select from any non-fault state: release and report
                state        <= S_FAULT;
                sel_valid_q  <= 1'b0;
                miso_oe_q    <= 1'b0;
                miso_out_q   <= PARK_VAL;
                contention_q <= 1'b1;
                err_sticky_q <= 1'b1;
                if (bus.err_clr)
                    err_count_q <= ERRCNT_W'(1);
                else if (!(&err_count_q))
                    err_count_q <= err_count_q + 1'b1;
            end else begin
                if (bus.err_clr) begin
                    err_sticky_q <= 1'b0;
                    err_count_q  <= '0;
                end
                case (state)
                    S_IDLE: begin
                        if (dec_one) begin
                            sel_idx_q   <= low_idx;
                            sel_valid_q <= 1'b1;
                            if (TURN_CYC == 0) begin
                                state      <= S_DRIVE;
                                miso_oe_q  <= 1'b1;
                                miso_out_q <= bus.miso_in[low_idx];
                            end else begin
                                state    <= S_TURN;
                                turn_cnt <= TURN_LOAD;
                            end
                        end
                    end
                    S_TURN: begin
                        if (dec_none) begin
                            state       <= S_IDLE;
                            sel_valid_q <= 1'b0;
                        end else if (dec_one) begin
                            if (low_idx != sel_idx_q) begin
                                sel_idx_q <= low_idx;
                                turn_cnt  <= TURN_LOAD;
                            end else if (turn_cnt == 4'd0) begin
                                state      <= S_DRIVE;
                                miso_oe_q  <= 1'b1;
                                miso_out_q <= bus.miso_in[sel_idx_q];
                            end else begin
                                turn_cnt <= turn_cnt - 1'b1;
                            end
                        end
                    end
                    S_DRIVE: begin
                        if (dec_none) begin
                            state       <= S_IDLE;
                            sel_valid_q <= 1'b0;
                            miso_oe_q   <= 1'b0;
                            miso_out_q  <= PARK_VAL;
                        end else if (dec_one) begin
                            if (low_idx == sel_idx_q) begin
                                miso_out_q <= bus.miso_in[sel_idx_q];
                            end else begin
                                // Break before make: release for the turnaround
                                state      <= S_TURN;
                                sel_idx_q  <= low_idx;
                                turn_cnt   <= TURN_LOAD;
                                miso_oe_q  <= 1'b0;
                                miso_out_q <= PARK_VAL;
                            end
                        end
                    end
                    S_FAULT: begin
                        // Only a full release clears the fault
                        if (dec_none) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.miso_out   = miso_out_q;
    assign bus.miso_oe    = miso_oe_q;
    assign bus.sel_idx    = sel_idx_q;
    assign bus.sel_valid  = sel_valid_q;
    assign bus.contention = contention_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_miso_bus_arbiter.sv
// Bench for miso_bus_arbiter: three configurations share one stimulus stream.
// A directed vector table and a hand sequence pin the documented corner cases;
// a run-length reference model checks every configuration on every edge.
module tb_miso_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cs_n;
    logic [3:0] miso_in;
    logic       err_clr;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    // Config 0: TURN 1, 2-bit counter. Config 1: TURN 0. Config 2: TURN 3, park 0.
    localparam int   TC [3] = '{1, 0, 3};
    localparam bit   PK [3] = '{1'b1, 1'b1, 1'b0};
    localparam int   EW [3] = '{2, 8, 3};

    miso_bus_arbiter_if #(.NSLAVE(4), .ERRCNT_W(2)) ifa ();
    miso_bus_arbiter_if #(.NSLAVE(4), .ERRCNT_W(8)) ifb ();
    miso_bus_arbiter_if #(.NSLAVE(4), .ERRCNT_W(3)) ifc ();

    assign ifa.cs_n = cs_n;  assign ifa.miso_in = miso_in;  assign ifa.err_clr = err_clr;
    assign ifb.cs_n = cs_n;  assign ifb.miso_in = miso_in;  assign ifb.err_clr = err_clr;
    assign ifc.cs_n = cs_n;  assign ifc.miso_in = miso_in;  assign ifc.err_clr = err_clr;

    miso_bus_arbiter #(.NSLAVE(4), .TURN_CYC(1), .PARK_VAL(1'b1), .ERRCNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    miso_bus_arbiter #(.NSLAVE(4), .TURN_CYC(0), .PARK_VAL(1'b1), .ERRCNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));
    miso_bus_arbiter #(.NSLAVE(4), .TURN_CYC(3), .PARK_VAL(1'b0), .ERRCNT_W(3)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc.slave));

    // {cnt[7:0], sticky, contention, idx[1:0], valid, out, oe, 0}; idx hidden unless keep
    function automatic logic [15:0] pack(logic oe, logic out, logic sv, logic [1:0] idx,
                                         logic con, logic stk, logic [7:0] cnt, bit keep);
        return {cnt, stk, con, (keep ? idx : 2'b00), sv, out, oe, 1'b0};
    endfunction

    function automatic logic [15:0] act_pack(int c, bit keep_idx);
        case (c)
            0: return pack(ifa.miso_oe, ifa.miso_out, ifa.sel_valid, ifa.sel_idx, ifa.contention,
                           ifa.err_sticky, 8'(ifa.err_count), keep_idx || (ifa.sel_valid === 1'b1));
            1: return pack(ifb.miso_oe, ifb.miso_out, ifb.sel_valid, ifb.sel_idx, ifb.contention,
                           ifb.err_sticky, 8'(ifb.err_count), keep_idx || (ifb.sel_valid === 1'b1));
            default: return pack(ifc.miso_oe, ifc.miso_out, ifc.sel_valid, ifc.sel_idx, ifc.contention,
                           ifc.err_sticky, 8'(ifc.err_count), keep_idx || (ifc.sel_valid === 1'b1));
        endcase
    endfunction

    task automatic cmp(string name, logic [15:0] act, logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cnt,stk,con,idx,sv,out,oe)", name, act, exp);
    endtask

    // Reference model: tracks how long the same single select has been held
    // unbroken and whether that run began from an idle bus.
    bit m_fault[3], m_prev_one[3], m_from_idle[3];
    int m_age[3], m_prev_k[3], m_cnt[3];
    bit m_oe[3], m_out[3], m_sv[3], m_con[3], m_stk[3];
    int m_idx[3];

    task automatic model_step();
        int zeros, k, need;
        bit one, none, entry;
        zeros = $countones(~cs_n);
        none  = (zeros == 0);
        one   = (zeros == 1);
        k = 0;
        for (int i = 0; i < 4; i++) if (!cs_n[i]) k = i;
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                m_fault[c] = 0; m_prev_one[c] = 0; m_from_idle[c] = 0; m_age[c] = 0;
                m_prev_k[c] = 0; m_cnt[c] = 0; m_stk[c] = 0; m_con[c] = 0;
                m_oe[c] = 0; m_out[c] = PK[c]; m_sv[c] = 0; m_idx[c] = 0;
            end else begin
                entry = (zeros >= 2) && !m_fault[c];
                m_con[c] = entry;
                if (entry) begin
                    m_stk[c] = 1;
                    m_cnt[c] = err_clr ? 1 : ((m_cnt[c] + 1 > (1 << EW[c]) - 1) ? m_cnt[c] : m_cnt[c] + 1);
                end else if (err_clr) begin
                    m_stk[c] = 0;
                    m_cnt[c] = 0;
                end
                if (entry) m_fault[c] = 1;
                else if (m_fault[c] && none) m_fault[c] = 0;
                if (one && !m_fault[c]) begin
                    if (m_prev_one[c] && m_prev_k[c] == k) m_age[c]++;
                    else begin
                        m_from_idle[c] = !m_prev_one[c];
                        m_age[c] = 1;
                    end
                end
                need = (m_from_idle[c] || TC[c] > 0) ? TC[c] + 1 : 2;
                m_sv[c]  = one && !m_fault[c];
                m_oe[c]  = m_sv[c] && (m_age[c] >= need);
                m_out[c] = m_oe[c] ? miso_in[k] : PK[c];
                if (m_sv[c]) m_idx[c] = k;
                m_prev_one[c] = m_sv[c];
                m_prev_k[c]   = k;
            end
        end
    endtask

    // One clock: advance model, then compare every config away from the edge
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < 3; c++)
            cmp($sformatf("model_cfg%0d", c), act_pack(c, 1'b0),
                pack(m_oe[c], m_out[c], m_sv[c], 2'(m_idx[c]), m_con[c], m_stk[c], 8'(m_cnt[c]), m_sv[c]));
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] cs;
        logic [3:0] mi;
        bit         clr;
        bit         oe, out, sv;
        logic [1:0] idx;
        bit         con, stk;
        logic [1:0] cnt;
    } vec_t;

    function automatic vec_t v(bit r, logic [3:0] cs, logic [3:0] mi, bit clr, bit oe, bit out,
                               bit sv, logic [1:0] idx, bit con, bit stk, logic [1:0] cnt);
        vec_t t;
        t.rst = r; t.cs = cs; t.mi = mi; t.clr = clr; t.oe = oe; t.out = out; t.sv = sv;
        t.idx = idx; t.con = con; t.stk = stk; t.cnt = cnt;
        return t;
    endfunction

    task automatic hcheck(string name, bit oe, bit out, bit sv, logic [1:0] idx,
                          bit con, bit stk, logic [7:0] cnt, bit keep);
        cmp(name, act_pack(1, keep), pack(oe, out, sv, idx, con, stk, cnt, keep || sv));
    endtask

    vec_t tbl[$];

    initial begin
        int r;
        logic [3:0] x;
        rst = 1'b1; cs_n = 4'hF; miso_in = 4'h0; err_clr = 1'b0;

        // Directed vectors for config 0 (TURN 1, park 1, 2-bit counter)
        //             rst cs     mi     clr oe out sv idx con stk cnt
        tbl.push_back(v(1, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0)); // reset
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'hB, 4'h4, 0, 0, 1, 1, 2'd2, 0, 0, 2'd0)); // select slave 2
        tbl.push_back(v(0, 4'hB, 4'h0, 0, 1, 0, 1, 2'd2, 0, 0, 2'd0)); // drives 2nd edge
        tbl.push_back(v(0, 4'hB, 4'h4, 0, 1, 1, 1, 2'd2, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'hB, 4'hB, 0, 1, 0, 1, 2'd2, 0, 0, 2'd0)); // others ignored
        tbl.push_back(v(0, 4'hB, 4'h4, 0, 1, 1, 1, 2'd2, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0)); // release
        tbl.push_back(v(0, 4'hE, 4'h1, 0, 0, 1, 1, 2'd0, 0, 0, 2'd0)); // slave 0
        tbl.push_back(v(0, 4'hE, 4'h0, 0, 1, 0, 1, 2'd0, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'hD, 4'h2, 0, 0, 1, 1, 2'd1, 0, 0, 2'd0)); // switch to 1
        tbl.push_back(v(0, 4'hD, 4'h0, 0, 1, 0, 1, 2'd1, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'hD, 4'h2, 0, 1, 1, 1, 2'd1, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'hC, 4'h0, 0, 0, 1, 0, 2'd0, 1, 1, 2'd1)); // contention
        tbl.push_back(v(0, 4'hD, 4'h2, 0, 0, 1, 0, 2'd0, 0, 1, 2'd1)); // ONE stays fault
        tbl.push_back(v(0, 4'hD, 4'h2, 0, 0, 1, 0, 2'd0, 0, 1, 2'd1));
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 1, 2'd1)); // back to idle
        tbl.push_back(v(0, 4'hD, 4'h0, 0, 0, 1, 1, 2'd1, 0, 1, 2'd1));
        tbl.push_back(v(0, 4'h0, 4'h0, 0, 0, 1, 0, 2'd0, 1, 1, 2'd2)); // fault from TURN
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 1, 2'd2));
        tbl.push_back(v(0, 4'h3, 4'h0, 0, 0, 1, 0, 2'd0, 1, 1, 2'd3));
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 1, 2'd3));
        tbl.push_back(v(0, 4'h6, 4'h0, 0, 0, 1, 0, 2'd0, 1, 1, 2'd3)); // saturated
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 1, 2'd3));
        tbl.push_back(v(0, 4'hC, 4'h0, 0, 0, 1, 0, 2'd0, 1, 1, 2'd3));
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 1, 2'd3));
        tbl.push_back(v(0, 4'hF, 4'h0, 1, 0, 1, 0, 2'd0, 0, 0, 2'd0)); // clear
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'hA, 4'h0, 1, 0, 1, 0, 2'd0, 1, 1, 2'd1)); // clear + entry
        tbl.push_back(v(0, 4'hF, 4'h0, 0, 0, 1, 0, 2'd0, 0, 1, 2'd1));
        tbl.push_back(v(0, 4'hF, 4'h0, 1, 0, 1, 0, 2'd0, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'h7, 4'h8, 0, 0, 1, 1, 2'd3, 0, 0, 2'd0));
        tbl.push_back(v(0, 4'h7, 4'h8, 0, 1, 1, 1, 2'd3, 0, 0, 2'd0));
        tbl.push_back(v(1, 4'h7, 4'h8, 0, 0, 1, 0, 2'd0, 0, 0, 2'd0)); // reset mid-drive

        foreach (tbl[i]) begin
            rst = tbl[i].rst; cs_n = tbl[i].cs; miso_in = tbl[i].mi; err_clr = tbl[i].clr;
            step();
            cmp($sformatf("vec%0d", i), act_pack(0, tbl[i].rst),
                pack(tbl[i].oe, tbl[i].out, tbl[i].sv, tbl[i].idx, tbl[i].con,
                     tbl[i].stk, 8'(tbl[i].cnt), tbl[i].sv || tbl[i].rst));
        end

        // Zero-turnaround config: one-edge select, switch, reset mid-drive
        rst = 1'b1; cs_n = 4'hF; miso_in = 4'h0; err_clr = 1'b0; step();
        rst = 1'b0; cs_n = 4'hC; step();
        hcheck("t0_fault", 0, 1, 0, 2'd0, 1, 1, 8'd1, 0);
        cs_n = 4'hF; step();
        cs_n = 4'hB; miso_in = 4'h4; step();
        hcheck("t0_drive_1edge", 1, 1, 1, 2'd2, 0, 1, 8'd1, 0);
        miso_in = 4'h0; step();
        hcheck("t0_follow", 1, 0, 1, 2'd2, 0, 1, 8'd1, 0);
        cs_n = 4'hE; miso_in = 4'h1; step();
        hcheck("t0_switch_break", 0, 1, 1, 2'd0, 0, 1, 8'd1, 0);
        step();
        hcheck("t0_switch_make", 1, 1, 1, 2'd0, 0, 1, 8'd1, 0);
        rst = 1'b1; step();
        hcheck("t0_reset_mid_drive", 0, 1, 0, 2'd0, 0, 0, 8'd0, 1);
        rst = 1'b0; cs_n = 4'hF;

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(99);
            if (r < 20) cs_n = 4'hF;
            else if (r < 38) cs_n = ~(4'b0001 << $urandom_range(3));
            else if (r < 45) begin
                x = 4'($urandom_range(15));
                while ($countones(~x) < 2) x = 4'($urandom_range(15));
                cs_n = x;
            end
            miso_in = 4'($urandom_range(15));
            err_clr = ($urandom_range(19) == 0);
            rst = ($urandom_range(149) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
